// File: rtl/wspr_symbol_sequencer.sv
// -----------------------------------------------------------------------------
// wspr_symbol_sequencer
//
// Steps through a WSPR symbol table and drives the NCO tuning word. Each symbol
// is held for SYMBOL_TICKS cycles. The word for a symbol is
// tuningWord = latchedBase + symbol*latchedStep, modulo 2^WORD_W.
// tuningWordValid is a one-cycle strobe whenever the word is reloaded.
//
// Optional feature: define WSPR_GUARD_EN to insert a GUARD_TICKS settle period
// between an accepted start and the first symbol. During that period the block
// is busy but the PA stays disabled. If GUARD_TICKS is 0, the build behaves as
// if the macro were undefined.
//
// Ports:
//   sysClk          in   system clock
//   nReset          in   asynchronous active-low reset
//   baseWord        in   tuning word for tone 0 (latched on start)
//   toneStep        in   tuning-word delta between tones (latched on start)
//   symWrEn         in   symbol-table write strobe (honoured only in IDLE)
//   symWrAddr       in   symbol-table write address
//   symWrData       in   symbol value 0..3
//   start           in   single-cycle frame start request
//   abort           in   single-cycle abort request (wins over start)
//   busy            out  frame in progress
//   txEnable        out  PA enable, high while symbols are transmitting
//   tuningWord      out  NCO tuning word, 0 when not transmitting
//   tuningWordValid out  one-cycle strobe on each tuningWord reload
//   symIndex        out  index of the current symbol
//   done            out  one-cycle pulse after the last symbol ends normally
// -----------------------------------------------------------------------------
module wspr_symbol_sequencer #(
    parameter int NUM_SYMBOLS  = 162,
    parameter int SYMBOL_TICKS = 122880000,
    parameter int GUARD_TICKS  = 18000000,
    parameter int WORD_W       = 32
) (
    input  logic              sysClk,
    input  logic              nReset,
    input  logic [WORD_W-1:0] baseWord,
    input  logic [WORD_W-1:0] toneStep,
    input  logic              symWrEn,
    input  logic [7:0]        symWrAddr,
    input  logic [1:0]        symWrData,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              txEnable,
    output logic [WORD_W-1:0] tuningWord,
    output logic              tuningWordValid,
    output logic [7:0]        symIndex,
    output logic              done
);

    localparam int MAX_TICKS = (SYMBOL_TICKS > GUARD_TICKS) ? SYMBOL_TICKS : GUARD_TICKS;
    localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
    localparam int AW        = (NUM_SYMBOLS > 1) ? $clog2(NUM_SYMBOLS) : 1;

    localparam logic [CNT_W-1:0] SYM_LAST = CNT_W'(SYMBOL_TICKS - 1);
    localparam logic [7:0]       IDX_LAST = 8'(NUM_SYMBOLS - 1);

`ifdef WSPR_GUARD_EN
    typedef enum logic [1:0] {S_IDLE, S_GUARD, S_SYMBOL, S_DONE} state_t;
    localparam bit               GUARD_ON   = (GUARD_TICKS != 0);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_TICKS - 1);
`else
    typedef enum logic [1:0] {S_IDLE, S_SYMBOL, S_DONE} state_t;
`endif

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    tick_q, tick_d;
    logic [WORD_W-1:0]   base_q, base_d;
    logic [WORD_W-1:0]   step_q, step_d;
    logic                busy_q, busy_d;
    logic                tx_q, tx_d;
    logic [WORD_W-1:0]   tw_q, tw_d;
    logic                twv_q, twv_d;
    logic [7:0]          idx_q, idx_d;
    logic                done_q, done_d;

    // Symbol table with registered read. The read address runs one symbol
    // ahead, so the next symbol is already in sym_rd_q when a boundary arrives
    // (SYMBOL_TICKS >= 2 guarantees the read has settled). When not
    // transmitting, entry 0 is prefetched so the first word can be produced
    // in the cycle after start.
    logic [1:0]          sym_mem [0:NUM_SYMBOLS-1];
    logic [1:0]          sym_rd_q;
    logic [7:0]          rd_addr;
    logic [AW-1:0]       rd_idx;
    logic                wr_ok;

    assign wr_ok   = symWrEn && (state_q == S_IDLE) && ({1'b0, symWrAddr} < 9'(NUM_SYMBOLS));
    assign rd_addr = (state_q == S_SYMBOL) ? (idx_q + 8'd1) : 8'd0;
    assign rd_idx  = ({1'b0, rd_addr} < 9'(NUM_SYMBOLS)) ? rd_addr[AW-1:0] : '0;

    always_ff @(posedge sysClk) begin
        if (wr_ok) begin
            sym_mem[symWrAddr[AW-1:0]] <= symWrData;
        end
        // Forward a same-cycle write so a start right after a table write
        // sees the new entry 0.
        if (wr_ok && (symWrAddr == rd_addr)) begin
            sym_rd_q <= symWrData;
        end else begin
            sym_rd_q <= sym_mem[rd_idx];
        end
    end

    function automatic logic [WORD_W-1:0] word_of(input logic [1:0]        s,
                                                   input logic [WORD_W-1:0] b,
                                                   input logic [WORD_W-1:0] st);
        return b + (WORD_W'(s) * st);
    endfunction

    always_ff @(posedge sysClk or negedge nReset) begin
        if (!nReset) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            base_q  <= '0;
            step_q  <= '0;
            busy_q  <= 1'b0;
            tx_q    <= 1'b0;
            tw_q    <= '0;
            twv_q   <= 1'b0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            base_q  <= base_d;
            step_q  <= step_d;
            busy_q  <= busy_d;
            tx_q    <= tx_d;
            tw_q    <= tw_d;
            twv_q   <= twv_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        base_d  = base_q;
        step_d  = step_q;
        busy_d  = busy_q;
        tx_d    = tx_q;
        tw_d    = tw_q;
        twv_d   = 1'b0;
        idx_d   = idx_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    base_d = baseWord;
                    step_d = toneStep;
                    busy_d = 1'b1;
                    tick_d = '0;
                    idx_d  = '0;
`ifdef WSPR_GUARD_EN
                    if (GUARD_ON) begin
                        state_d = S_GUARD;
                        tx_d    = 1'b0;
                        tw_d    = '0;
                    end else begin
                        state_d = S_SYMBOL;
                        tx_d    = 1'b1;
                        tw_d    = word_of(sym_rd_q, baseWord, toneStep);
                        twv_d   = 1'b1;
                    end
`else
                    state_d = S_SYMBOL;
                    tx_d    = 1'b1;
                    tw_d    = word_of(sym_rd_q, baseWord, toneStep);
                    twv_d   = 1'b1;
`endif
                end
            end
`ifdef WSPR_GUARD_EN
            S_GUARD: begin
                if (abort) begin
                    // The word is already 0 here, so no strobe is issued.
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    tick_d  = '0;
                end else if (tick_q == GUARD_LAST) begin
                    state_d = S_SYMBOL;
                    tick_d  = '0;
                    tx_d    = 1'b1;
                    tw_d    = word_of(sym_rd_q, base_q, step_q);
                    twv_d   = 1'b1;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
`endif
            S_SYMBOL: begin
                if (abort) begin
                    state_d = S_IDLE;
                    tick_d  = '0;
                    busy_d  = 1'b0;
                    tx_d    = 1'b0;
                    tw_d    = '0;
                    twv_d   = 1'b1;
                    idx_d   = '0;
                end else if (tick_q == SYM_LAST) begin
                    tick_d = '0;
                    twv_d  = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        tx_d    = 1'b0;
                        tw_d    = '0;
                    end else begin
                        idx_d = idx_q + 8'd1;
                        tw_d  = word_of(sym_rd_q, base_q, step_q);
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                idx_d   = '0;
                if (abort) begin
                    tw_d  = '0;
                    twv_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy            = busy_q;
    assign txEnable        = tx_q;
    assign tuningWord      = tw_q;
    assign tuningWordValid = twv_q;
    assign symIndex        = idx_q;
    assign done            = done_q;

endmodule
